// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO with registered flags, a full-range used-word
// count, almost_full/almost_empty thresholds, a synchronous clear and two
// read styles (SHOWAHEAD "OFF" registered read, "ON" head word on q_o).
// Optional build macro: SC_FIFO_ERR_FLAGS_EN adds sticky ovf_o/udf_o ports
// that record a write request while full or a read request while empty.
module sc_fifo #(
  parameter int    DWIDTH       = 8,
  parameter int    AWIDTH       = 3,
  parameter string SHOWAHEAD    = "OFF",
  parameter int    ALMOST_FULL  = 6,
  parameter int    ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              aclr_i,
  input  logic              sclr_i,
  input  logic              wr_req_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rd_req_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
`ifdef SC_FIFO_ERR_FLAGS_EN
  ,
  output logic              ovf_o,
  output logic              udf_o
`endif
);

  localparam int DEPTH = 1 << AWIDTH;

  // Reject configurations that would make the flags meaningless.
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
    $error("sc_fifo: ALMOST_FULL must be in 1..2**AWIDTH");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH) begin : g_bad_ae
    $error("sc_fifo: ALMOST_EMPTY must be in 0..2**AWIDTH");
  end
  if (SHOWAHEAD != "ON" && SHOWAHEAD != "OFF") begin : g_bad_sa
    $error("sc_fifo: SHOWAHEAD must be \"ON\" or \"OFF\"");
  end

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH:0]   wr_ptr, rd_ptr;
  logic [AWIDTH:0]   wr_ptr_n, rd_ptr_n;
  logic [AWIDTH:0]   usedw_n;
  logic              wr_acc, rd_acc;
  logic [AWIDTH-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr[AWIDTH-1:0];
  assign rd_addr = rd_ptr[AWIDTH-1:0];

  // A clear wins over any request in the same cycle, so it also blocks them here.
  assign wr_acc = wr_req_i && !full_o  && !sclr_i;
  assign rd_acc = rd_req_i && !empty_o && !sclr_i;

  // Next pointers and count; both-or-neither leaves the count unchanged.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    usedw_n  = usedw_o;
    if (wr_acc) wr_ptr_n = wr_ptr + 1'b1;
    if (rd_acc) rd_ptr_n = rd_ptr + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_n = usedw_o + 1'b1;
      2'b01:   usedw_n = usedw_o - 1'b1;
      default: usedw_n = usedw_o;
    endcase
  end

  // Pointer, count and flag registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_o <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else if (sclr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_o <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      usedw_o <= usedw_n;
      // Equal pointers mean empty; same address with opposite wrap bits means full.
      empty_o <= (wr_ptr_n == rd_ptr_n);
      full_o  <= (wr_ptr_n[AWIDTH-1:0] == rd_ptr_n[AWIDTH-1:0]) &&
                 (wr_ptr_n[AWIDTH] != rd_ptr_n[AWIDTH]);
    end
  end

  // Storage write.
  // NOTE: the array has no reset on purpose; pointers alone define which
  // words are valid, and a resettable array would become a huge flop bank.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_addr] <= data_i;
  end

  // Thresholds come straight off the registered count, no added latency.
  assign almost_full_o  = (usedw_o >= (AWIDTH+1)'(ALMOST_FULL));
  assign almost_empty_o = (usedw_o <  (AWIDTH+1)'(ALMOST_EMPTY));

  if (SHOWAHEAD == "ON") begin : g_showahead
    // Head word is presented whenever data is stored; forced to 0 while empty
    // so the output is never driven from an unwritten location.
    assign q_o = empty_o ? '0 : mem[rd_addr];
  end else begin : g_normal
    logic [DWIDTH-1:0] q_reg;

    // Registered read port: loads the word at rd_ptr on an accepted read only.
    always_ff @(posedge clk_i or posedge aclr_i) begin
      if (aclr_i)      q_reg <= '0;
      else if (sclr_i) q_reg <= '0;
      else if (rd_acc) q_reg <= mem[rd_addr];
    end

    assign q_o = q_reg;
  end

`ifdef SC_FIFO_ERR_FLAGS_EN
  // Sticky overflow/underflow flags; only a reset or clear removes them.
  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else if (sclr_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (wr_req_i && full_o)  ovf_o <= 1'b1;
      if (rd_req_i && empty_o) udf_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: one instance per SHOWAHEAD mode, driven by the
// same stimulus and checked against an expected-content queue.
module tb_sc_fifo;

  logic       clk = 1'b0;
  logic       aclr, sclr, wr, rd;
  logic [7:0] data;

  logic [7:0] q_off, q_on;
  logic       empty_off, empty_on, full_off, full_on;
  logic [3:0] usedw_off, usedw_on;
  logic       af_off, af_on, ae_off, ae_on;
`ifdef SC_FIFO_ERR_FLAGS_EN
  logic       ovf_off, ovf_on, udf_off, udf_on;
  logic       ovf_exp, udf_exp;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_off;

  always #5 clk = ~clk;

  sc_fifo #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("OFF"), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut_off (
    .clk_i(clk), .aclr_i(aclr), .sclr_i(sclr), .wr_req_i(wr), .data_i(data), .rd_req_i(rd),
    .q_o(q_off), .empty_o(empty_off), .full_o(full_off), .usedw_o(usedw_off),
    .almost_full_o(af_off), .almost_empty_o(ae_off)
`ifdef SC_FIFO_ERR_FLAGS_EN
    , .ovf_o(ovf_off), .udf_o(udf_off)
`endif
  );

  sc_fifo #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("ON"), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut_on (
    .clk_i(clk), .aclr_i(aclr), .sclr_i(sclr), .wr_req_i(wr), .data_i(data), .rd_req_i(rd),
    .q_o(q_on), .empty_o(empty_on), .full_o(full_on), .usedw_o(usedw_on),
    .almost_full_o(af_on), .almost_empty_o(ae_on)
`ifdef SC_FIFO_ERR_FLAGS_EN
    , .ovf_o(ovf_on), .udf_o(udf_on)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Flags for both instances against a given word count.
  task automatic chk_state(input string tag, input int cnt);
    check({tag, " usedw_off"}, 32'(usedw_off), 32'(cnt));
    check({tag, " usedw_on"},  32'(usedw_on),  32'(cnt));
    check({tag, " empty_off"}, 32'(empty_off), 32'(cnt == 0));
    check({tag, " empty_on"},  32'(empty_on),  32'(cnt == 0));
    check({tag, " full_off"},  32'(full_off),  32'(cnt == 8));
    check({tag, " full_on"},   32'(full_on),   32'(cnt == 8));
    check({tag, " af_off"},    32'(af_off),    32'(cnt >= 6));
    check({tag, " af_on"},     32'(af_on),     32'(cnt >= 6));
    check({tag, " ae_off"},    32'(ae_off),    32'(cnt < 2));
    check({tag, " ae_on"},     32'(ae_on),     32'(cnt < 2));
`ifdef SC_FIFO_ERR_FLAGS_EN
    check({tag, " ovf_off"}, 32'(ovf_off), 32'(ovf_exp));
    check({tag, " ovf_on"},  32'(ovf_on),  32'(ovf_exp));
    check({tag, " udf_off"}, 32'(udf_off), 32'(udf_exp));
    check({tag, " udf_on"},  32'(udf_on),  32'(udf_exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given requests; expected content follows the
  // accept rules (no write when full, no read when empty).
  task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    wr = w; rd = r; data = d;
    wa = w && (exp_q.size() < 8);
    ra = r && (exp_q.size() > 0);
    if (exp_q.size() > 0) check({tag, " q_on head"}, 32'(q_on), 32'(exp_q[0]));
`ifdef SC_FIFO_ERR_FLAGS_EN
    if (w && exp_q.size() == 8) ovf_exp = 1'b1;
    if (r && exp_q.size() == 0) udf_exp = 1'b1;
`endif
    tick();
    if (ra) last_off = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    check({tag, " q_off"}, 32'(q_off), 32'(last_off));
    chk_state(tag, exp_q.size());
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    aclr = 1'b0; sclr = 1'b0; wr = 1'b0; rd = 1'b0; data = 8'h00;
    last_off = 8'h00;
`ifdef SC_FIFO_ERR_FLAGS_EN
    ovf_exp = 1'b0; udf_exp = 1'b0;
`endif

    // 1: asynchronous reset takes effect between clock edges.
    #2 aclr = 1'b1;
    #1;
    chk_state("reset", 0);
    check("reset q_off", 32'(q_off), 32'h0);
    check("reset q_on",  32'(q_on),  32'h0);
    #5 aclr = 1'b0;
    tick();
    chk_state("post-reset", 0);

    // 2: fill with eight words, then one write that must be ignored.
    begin
      logic [7:0] words [8];
      words = '{8'h3C, 8'hA5, 8'h01, 8'hFF, 8'h5A, 8'h80, 8'h7E, 8'hC3};
      for (int i = 0; i < 8; i++) begin
        cycle($sformatf("fill%0d", i), 1'b1, 1'b0, words[i]);
        check($sformatf("fill%0d usedw", i), 32'(usedw_off), 32'(i + 1));
      end
      check("fill head on", 32'(q_on), 32'h3C);
      check("fill q_off held", 32'(q_off), 32'h0);
      cycle("ovf write", 1'b1, 1'b0, 8'hEE);
      check("ovf usedw", 32'(usedw_off), 32'd8);

      // 3: drain in order, then one read that must be ignored.
      for (int i = 0; i < 8; i++) begin
        cycle($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00);
        check($sformatf("drain%0d data", i), 32'(q_off), 32'(words[i]));
      end
      cycle("udf read", 1'b0, 1'b1, 8'h00);
      check("udf q_off held", 32'(q_off), 32'hC3);
    end

    // 4: steady state at four words with simultaneous read and write.
    for (int i = 0; i < 4; i++) cycle($sformatf("pre%0d", i), 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("rw%0d", i), 1'b1, 1'b1, 8'(8'h40 + 3 * i));
      check($sformatf("rw%0d usedw", i), 32'(usedw_on), 32'd4);
    end
    for (int i = 0; i < 4; i++) cycle($sformatf("post%0d", i), 1'b0, 1'b1, 8'h00);
    check("rw last word", 32'(q_off), 32'(8'h40 + 3 * 19));

    // 5: read+write when empty writes only; when full reads only.
    cycle("rw empty", 1'b1, 1'b1, 8'h99);
    check("rw empty usedw", 32'(usedw_off), 32'd1);
    for (int i = 0; i < 7; i++) cycle($sformatf("refill%0d", i), 1'b1, 1'b0, 8'(8'hB0 + i));
    cycle("rw full", 1'b1, 1'b1, 8'h77);
    check("rw full usedw", 32'(usedw_off), 32'd7);
    check("rw full data", 32'(q_off), 32'h99);

    // 6: synchronous clear at five words overrides a same-cycle write.
    cycle("to5 a", 1'b0, 1'b1, 8'h00);
    cycle("to5 b", 1'b0, 1'b1, 8'h00);
    check("to5 usedw", 32'(usedw_off), 32'd5);
    sclr = 1'b1; wr = 1'b1; data = 8'hDD;
    tick();
    sclr = 1'b0; wr = 1'b0;
    exp_q.delete();
    last_off = 8'h00;
`ifdef SC_FIFO_ERR_FLAGS_EN
    ovf_exp = 1'b0; udf_exp = 1'b0;
`endif
    chk_state("sclr", 0);
    check("sclr q_off", 32'(q_off), 32'h0);
    cycle("after sclr", 1'b1, 1'b0, 8'h5A);
    check("after sclr head", 32'(q_on), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
